data_bus_responder: RTL and testbench

Memory-side responder for the 16-bit single-cycle CPU's data port. It decodes the CPU's data address/write-enable/write-data bundle, serves a word RAM and a small memory-mapped I/O page, and returns read data combinationally in the same cycle. The I/O page carries a free-running cycle counter and a transmit FIFO that an external consumer drains through a valid/ready handshake. It sits between the CPU data outputs (`aluout`, `writedata`, `memwrite`) and its `readdata` input.

---
 rtl/data_bus_responder.sv | 130 +++++++++++++
 tb/tb_data_bus_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM plus an MMIO page holding a cycle counter,
// a transmit FIFO drained by valid/ready, and a saturating drop counter.
module data_bus_responder #(
    parameter int n          = 16,
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] addr,
    input  logic         memwrite,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic [n-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [n-1:0]  mem  [RAM_WORDS];
    logic [n-1:0]  fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [n-1:0]  cycle;
    logic [n-1:0]  drops;
    logic [n-1:0]  status;

    logic is_mmio;
    logic page_hit;
    logic sel_cycle;
    logic sel_status;
    logic sel_tx;
    logic sel_drops;
    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;
    logic drop;
    logic unused_ok;

    assign unused_ok  = addr[0];

    assign is_mmio    = addr[n-1];
    assign page_hit   = is_mmio && (addr[n-2:3] == '0);
    assign sel_cycle  = page_hit && (addr[2:1] == 2'd0);
    assign sel_status = page_hit && (addr[2:1] == 2'd1);
    assign sel_tx     = page_hit && (addr[2:1] == 2'd2);
    assign sel_drops  = page_hit && (addr[2:1] == 2'd3);

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && tx_ready;
    assign push_req = memwrite && sel_tx;
    // A pop on the same edge frees the slot, so a push at full still lands.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign tx_valid = !empty;
    assign tx_data  = empty ? '0 : fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio)
            mem[addr[AW:1]] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // A load counts as this cycle's tick on the loaded value.
    always_ff @(posedge clk) begin
        if (reset)
            cycle <= '0;
        else if (memwrite && sel_cycle)
            cycle <= writedata + 1'b1;
        else
            cycle <= cycle + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            drops <= '0;
        else if (memwrite && sel_drops)
            drops <= '0;
        else if (drop && (drops != '1))
            drops <= drops + 1'b1;
    end

    always_comb begin
        status          = '0;
        status[0]       = full;
        status[1]       = empty;
        status[2 +: CW] = count;
    end

    always_comb begin
        readdata = '0;
        unique case (1'b1)
            !is_mmio:   readdata = mem[addr[AW:1]];
            sel_cycle:  readdata = cycle;
            sel_status: readdata = status;
            sel_drops:  readdata = drops;
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed vector bench for data_bus_responder: RAM, CYCLE, STATUS,
// transmit FIFO ordering/overflow and mid-run reset.
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int compared = 0;
    int mismatched = 0;

    data_bus_responder #(.n(16), .RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .memwrite  (memwrite),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic        we;
        logic [15:0] wd;
        logic        rdy;
        logic        chk;
        logic [15:0] erd;
        logic        ev;
        logic [15:0] etx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [15:0] a,
                                input logic we, input logic [15:0] wd,
                                input logic rdy, input logic chk,
                                input logic [15:0] erd, input logic ev,
                                input logic [15:0] etx);
        vec_t t;
        t.rst = r; t.a = a; t.we = we; t.wd = wd; t.rdy = rdy;
        t.chk = chk; t.erd = erd; t.ev = ev; t.etx = etx;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] a, input logic we,
                         input logic [15:0] wd, input logic rdy);
        reset = r; addr = a; memwrite = we; writedata = wd; tx_ready = rdy;
    endtask

    initial begin
        drive(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // rst a we wd rdy chk erd ev etx
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0004, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0006, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0004, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0006, 0, 16'h0000, 0, 1, 16'h1234, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0084, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0005, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8000, 1, 16'hFFFE, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8000, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000));
        // fill, then overflow
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0011, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0022, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0033, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0044, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0055, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0011, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0001, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h800A, 1, 16'h5555, 0, 0, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h800A, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0001, 1, 16'h0011));
        // drain in order
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0011, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h000C, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0033));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0044));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000));
        // refill, then push+pop at full
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0011, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0022, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0033, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0044, 0, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0066, 1, 1, 16'h0000, 1, 16'h0011));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0011, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0001, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8006, 1, 16'h1234, 0, 1, 16'h0001, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0011, 1, 16'h0022));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h000C, 1, 16'h0033));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0044));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0066));
        // push into empty with ready high: no bypass, becomes head
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0077, 1, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0088, 0, 1, 16'h0000, 1, 16'h0077));
        vecs.push_back(mk(0, 16'h8004, 1, 16'h0099, 0, 1, 16'h0000, 1, 16'h0077));
        // reset with 3 queued, overriding a push and a pop
        vecs.push_back(mk(1, 16'h8004, 1, 16'h00AA, 1, 1, 16'h0000, 1, 16'h0077));
        vecs.push_back(mk(0, 16'h8002, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8006, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0004, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0006, 0, 16'h0000, 0, 1, 16'h1234, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h8000, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0000));

        // two reset edges, then CYCLE counts from 0
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h8000, 1'b0, 16'h0000, 1'b0);
        #1;
        check("rst cycle0", readdata, 16'h0000);
        check("rst valid", {15'd0, tx_valid}, 16'h0000);
        check("rst txdata", tx_data, 16'h0000);
        @(negedge clk);
        #1;
        check("rst cycle1", readdata, 16'h0001);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].rdy);
            #1;
            if (vecs[i].chk)
                check($sformatf("v%0d rd", i), readdata, vecs[i].erd);
            check($sformatf("v%0d valid", i), {15'd0, tx_valid},
                  {15'd0, vecs[i].ev});
            check($sformatf("v%0d txdata", i), tx_data, vecs[i].etx);
        end

        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
